// File: rtl/seg_display_system_pkg.sv
// Shared constants for the 4-digit 7-segment demo.
// Glyph table, default dividers and anode idle pattern.
package seg_display_system_pkg;

   localparam int REFRESH_DIV_DEF = 100000;
   localparam int COUNT_DIV_DEF   = 10000000;

   localparam logic [3:0] AN_OFF = 4'b1111;

   // active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_LUT [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // counter width for a divider, never below one bit
   function automatic int div_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/seg_display_system_hex_to_seg.sv
// Hex nibble to active-low 7-segment glyph.
// Purely combinational lookup.
module hex_to_seg
   import seg_display_system_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // table lookup of the glyph for this nibble
   always_comb begin
      seg = SEG_LUT[nib];
   end

endmodule

// File: rtl/seg_display_system.sv
// 4-digit common-anode display demo: free-running hex
// counter shown by time-multiplexed anode scanning.
module seg_display_system
   import seg_display_system_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEF,
   parameter int COUNT_DIV   = COUNT_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int CW = div_width(COUNT_DIV);
   localparam int RW = div_width(REFRESH_DIV);

   localparam logic [CW-1:0] CNT_MAX = CW'(COUNT_DIV - 1);
   localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

   logic [15:0]   value;
   logic [CW-1:0] cnt_div;
   logic [RW-1:0] ref_div;
   logic [1:0]    idx;

   logic       cnt_tick;
   logic       ref_tick;
   logic [3:0] nib;

   assign cnt_tick = (cnt_div == CNT_MAX);
   assign ref_tick = (ref_div == REF_MAX);

   // counter prescaler; value bumps on the wrap edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_div <= '0;
         value   <= '0;
      end else if (cnt_tick) begin
         cnt_div <= '0;
         value   <= value + 16'd1;
      end else begin
         cnt_div <= cnt_div + CW'(1);
      end
   end

   // scan prescaler; digit index advances on the wrap edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_div <= '0;
         idx     <= '0;
      end else if (ref_tick) begin
         ref_div <= '0;
         idx     <= idx + 2'd1;
      end else begin
         ref_div <= ref_div + RW'(1);
      end
   end

   // pick the nibble belonging to the active digit
   always_comb begin
      nib = value[3:0];
      unique case (idx)
         2'd0: nib = value[3:0];
         2'd1: nib = value[7:4];
         2'd2: nib = value[11:8];
         2'd3: nib = value[15:12];
         default: nib = value[3:0];
      endcase
   end

   hex_to_seg u_dec (
      .nib (nib),
      .seg (seg)
   );

   // one anode low, selected straight from idx
   always_comb begin
      an = AN_OFF ^ (4'b0001 << idx);
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_system.sv
// Scoreboard bench for seg_display_system with small dividers.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_seg_display_system;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   seg_display_system #(
      .REFRESH_DIV (4),
      .COUNT_DIV   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .seg   (seg),
      .dp    (dp),
      .an    (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] ean;
      logic [6:0] eseg;
   } exp_t;

   exp_t q[$];
   event pushed;
   int   ncmp = 0;
   int   nbad = 0;
   logic [15:0] ldval;
   exp_t me;

   localparam logic [6:0] G [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // monitor: sample outputs 1 unit after a push
   initial begin
      forever begin
         @(pushed);
         #1;
         while (q.size() != 0) begin
            me = q.pop_front();
            ncmp++;
            if (an !== me.ean || seg !== me.eseg || dp !== 1'b1) begin
               nbad++;
               $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=1",
                        me.name, an, seg, dp, me.ean, me.eseg);
            end
         end
      end
   end

   task automatic expect_now(input string nm,
                             input logic [3:0] a,
                             input logic [6:0] s);
      exp_t x;
      x.name = nm;
      x.ean  = a;
      x.eseg = s;
      q.push_back(x);
      ->pushed;
      for (int i = 0; i < 4 && q.size() != 0; i++) #1;
      if (q.size() != 0) begin
         ncmp++;
         nbad++;
         $display("FAIL %s: monitor did not consume, pending=%0d want 0",
                  nm, q.size());
         q.delete();
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   task automatic load(input logic [15:0] v);
      ldval = v;
      force dut.value = ldval;
      #1;
      release dut.value;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, want finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] scan_an  [1:16];
   logic [6:0] scan_seg [1:16];

   initial begin
      scan_an = '{4'b1110, 4'b1110, 4'b1110,
                  4'b1101, 4'b1101, 4'b1101, 4'b1101,
                  4'b1011, 4'b1011, 4'b1011, 4'b1011,
                  4'b0111, 4'b0111, 4'b0111, 4'b0111,
                  4'b1110};
      for (int k = 1; k <= 15; k++) scan_seg[k] = 7'b1000000;
      scan_seg[16] = 7'b0100100;

      // async reset before any clock edge
      #2;
      reset = 1'b1;
      expect_now("rst_async", 4'b1110, 7'b1000000);
      tick(3);
      expect_now("rst_held", 4'b1110, 7'b1000000);
      reset = 1'b0;

      // scan sequence, value 0..2
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         expect_now($sformatf("scan_%0d", k), scan_an[k], scan_seg[k]);
      end

      // value 0x000A after 80 cycles
      tick(64);
      expect_now("cnt80_d0", 4'b1110, 7'b0001000);
      tick(4);
      expect_now("cnt84_d1", 4'b1101, 7'b1000000);
      tick(4);
      expect_now("cnt88_d2", 4'b1011, 7'b1000000);
      tick(4);
      expect_now("cnt92_d3", 4'b0111, 7'b1000000);

      // full glyph sweep on digit 0
      tick(1);
      for (int n = 0; n < 16; n++) begin
         pulse_reset();
         load(16'(n));
         expect_now($sformatf("sweep_%0h", n), 4'b1110, G[n]);
         tick(1);
      end

      // wrap from FFFF
      pulse_reset();
      load(16'hFFFF);
      expect_now("wrap_pre", 4'b1110, 7'b0001110);
      tick(8);
      expect_now("wrap_d2", 4'b1011, 7'b1000000);
      tick(4);
      expect_now("wrap_d3", 4'b0111, 7'b1000000);
      tick(4);
      expect_now("wrap_one_d0", 4'b1110, 7'b1111001);
      tick(4);
      expect_now("wrap_d1", 4'b1101, 7'b1000000);

      // reset mid-scan at idx 2, value 0x0123
      tick(1);
      pulse_reset();
      tick(8);
      load(16'h0123);
      expect_now("mid_pre", 4'b1011, 7'b1111001);
      reset = 1'b1;
      expect_now("mid_rst", 4'b1110, 7'b1000000);
      tick(2);
      expect_now("mid_held", 4'b1110, 7'b1000000);
      reset = 1'b0;
      tick(8);
      expect_now("mid_res_d2", 4'b1011, 7'b1000000);
      tick(8);
      expect_now("mid_res_d0", 4'b1110, 7'b0100100);

      tick(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/seg_display_system.md
Name: seg_display_system

Overview:
- Top-level demo block for a 4-digit common-anode 7-segment display.
- Keeps a free-running 16-bit hex counter and shows it on four digits.
- Scans the digits by time-multiplexing the anodes.
- Outputs drive board pins (seg, dp, an) directly; the only inputs are clock and reset.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays active before the scan advances (>=1).
- COUNT_DIV, 10000000: clock cycles between counter increments (>=1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- seg  output  7  segment drive, active-low; seg[0]=a, seg[1]=b, … seg[6]=g.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.

Behaviour:
- State:
  - value[15:0]: display counter.
  - cnt_div: counter prescaler, range 0..COUNT_DIV-1.
  - ref_div: scan prescaler, range 0..REFRESH_DIV-1.
  - idx[1:0]: active digit.
- Reset, asserted asynchronously: value=0, cnt_div=0, ref_div=0, idx=0. Outputs immediately become an=4'b1110, seg=7'b1000000 (glyph "0"), dp=1.
- Counter prescaler: cnt_div increments every clk. When cnt_div==COUNT_DIV-1 it wraps to 0 and value increments by 1 on that same edge.
- value wraps from 16'hFFFF to 16'h0000 with no flag.
- Scan prescaler: ref_div increments every clk. When ref_div==REFRESH_DIV-1 it wraps to 0 and idx increments by 1 on that same edge.
- idx wraps from 3 to 0.
- Digit select: an = ~(4'b0001 << idx). Exactly one anode is low at all times after reset.
- Nibble select:
  - idx 0 shows value[3:0]; idx 1 shows value[7:4].
  - idx 2 shows value[11:8]; idx 3 shows value[15:12].
- Hex decode, active-low {g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp is held at 1 (off) permanently.
- an and seg are a pure decode of the registered idx/value. They change on the same edge as idx or value, with no extra cycle of latency.
- Simultaneous ticks: when both prescalers expire on the same edge, value and idx both update and the outputs show the new digit with the new value.
- Reset mid-scan: all state returns to the reset values at once, with no dependence on the clock. Counting resumes on the first clk edge after reset deasserts.

Decomposition:
- Shared package holds:
  - the 16-entry SEG_LUT constant (active-low glyphs);
  - the default REFRESH_DIV and COUNT_DIV;
  - the AN_OFF=4'b1111 constant.
- One natural sub-module: hex_to_seg (4-bit nibble in, 7-bit active-low segments out, purely combinational).
- Prescalers, counter and scan mux stay in the top module.

Test Plan:
- Benches use REFRESH_DIV=4 and COUNT_DIV=8.
- Reset: assert reset for 3 cycles -> an=1110, seg=1000000, dp=1, value=0. Outputs change before any clk edge (async).
- Scan: after reset, 16 clk cycles -> an steps 1110, 1101, 1011, 0111, 1110, changing every 4 cycles. Exactly one anode is low in every cycle.
- Count: 8 cycles -> value=1; at idx 0, seg=1111001. After 80 cycles total -> value=0x000A, digit 0 shows 0001000 and digits 1–3 show 1000000.
- Wrap: force value to 16'hFFFF, then 8 cycles -> value=0x0000 and all digits decode to 1000000.
- Full decode sweep: step value through 0x0000..0x000F -> seg on idx 0 matches every LUT entry. Checked against the table above.
- Mid-run reset: assert reset while idx=2 and value=0x0123 -> an=1110, seg=1000000 immediately. Counting restarts from 0 after reset is released.
